// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit pipelined CPU: ALU classes, R-type function codes,
// forwarding selects and EX-stage state, used by decoder, hazard unit and EX/MEM stage.
package cpu_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_AND = 3'b010;
    localparam logic [2:0] FUNC_OR  = 3'b011;
    localparam logic [2:0] FUNC_XOR = 3'b100;
    localparam logic [2:0] FUNC_SLT = 3'b101;
    localparam logic [2:0] FUNC_MUL = 3'b110;
    localparam logic [2:0] FUNC_SHL = 3'b111;

    // 2'b11 is unused by the hazard unit and falls back to the ID/EX value
    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    typedef enum logic [1:0] {
        EX_IDLE = 2'b00,
        EX_MUL  = 2'b01,
        EX_DONE = 2'b10
    } ex_state_e;

    typedef struct packed {
        logic rwrite;
        logic mreg;
        logic mread;
        logic mwrite;
    } mem_ctl_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX-to-EX/MEM bundle: instruction fields and forwarding inputs in, EX/MEM register
// and upstream stall out. The stage uses the slave modport; the ID side uses master.
interface ex_mem_stage_if #(
    parameter int DW = 16
);
    import cpu_pkg::*;

    logic          flush_in;
    logic [DW-1:0] d1_in;
    logic [DW-1:0] d2_in;
    logic [DW-1:0] imm_in;
    logic [2:0]    wreg_in;
    logic [2:0]    func_in;
    logic [1:0]    aluop_in;
    logic          rwrite_in;
    logic          mreg_in;
    logic          mread_in;
    logic          mwrite_in;
    logic          asrc_in;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic [DW-1:0] mem_fwd_data;
    logic [DW-1:0] wb_fwd_data;

    logic [DW-1:0] alu_out;
    logic [DW-1:0] sdata_out;
    logic [2:0]    wreg_out;
    logic          rwrite_out;
    logic          mreg_out;
    logic          mread_out;
    logic          mwrite_out;
    logic          stall_out;

    modport master (
        output flush_in, d1_in, d2_in, imm_in, wreg_in, func_in, aluop_in,
               rwrite_in, mreg_in, mread_in, mwrite_in, asrc_in,
               fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
        input  alu_out, sdata_out, wreg_out, rwrite_out, mreg_out, mread_out,
               mwrite_out, stall_out
    );

    modport slave (
        input  flush_in, d1_in, d2_in, imm_in, wreg_in, func_in, aluop_in,
               rwrite_in, mreg_in, mread_in, mwrite_in, asrc_in,
               fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
        output alu_out, sdata_out, wreg_out, rwrite_out, mreg_out, mread_out,
               mwrite_out, stall_out
    );

endinterface

// File: rtl/mul16_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, MUL_LEN steps,
// keeping only the low DW bits of the product.
module mul16_iter
    import cpu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int MUL_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);
    localparam int CW = (MUL_LEN > 1) ? $clog2(MUL_LEN) : 1;

    logic [CW-1:0] cnt;
    logic [DW-1:0] mcand_p1;
    logic [DW-1:0] mplier_p1;
    logic [DW-1:0] acc_p1;

    // done marks the cycle whose edge performs the final step
    assign done    = busy && (cnt == CW'(MUL_LEN - 1));
    assign product = acc_p1;

    // start reloads even while busy, so an aborted run never leaks into the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand_p1  <= a;
            mplier_p1 <= b;
            acc_p1    <= '0;
        end else if (busy) begin
            acc_p1    <= acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage and EX/MEM pipeline register: operand forwarding, single-cycle ALU,
// iterative multiply sequenced by an IDLE/MUL/DONE FSM that stalls the front end.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int MUL_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);
    localparam int SHW = $clog2(DW);

    function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel,
                                              input logic [DW-1:0] idex,
                                              input logic [DW-1:0] mem,
                                              input logic [DW-1:0] wb);
        logic [DW-1:0] r;
        case (sel)
            FWD_MEM: r = mem;
            FWD_WB:  r = wb;
            default: r = idex;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] alu_fn(input logic [1:0] aluop,
                                             input logic [2:0] func,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0]        r;
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        sa = a;
        sb = b;
        r  = '0;
        case (aluop)
            ALUOP_MEM:  r = a + b;
            ALUOP_SUB:  r = a - b;
            ALUOP_PASS: r = b;
            default: begin
                case (func)
                    FUNC_ADD: r = a + b;
                    FUNC_SUB: r = a - b;
                    FUNC_AND: r = a & b;
                    FUNC_OR:  r = a | b;
                    FUNC_XOR: r = a ^ b;
                    FUNC_SLT: r = (sa < sb) ? DW'(1) : '0;
                    FUNC_SHL: r = a << b[SHW-1:0];
                    default:  r = '0;  // multiply result comes from mul16_iter
                endcase
            end
        endcase
        return r;
    endfunction

    ex_state_e     state;
    logic [DW-1:0] a_p0;
    logic [DW-1:0] bf_p0;
    logic [DW-1:0] b_p0;
    logic [DW-1:0] alu_p0;
    logic [DW-1:0] res_p0;
    logic          is_mul_p0;
    logic          take_p0;
    logic          stall_p0;
    mem_ctl_t      ctl_p0;

    logic [DW-1:0] alu_p1;
    logic [DW-1:0] sdata_p1;
    logic [2:0]    wreg_p1;
    mem_ctl_t      ctl_p1;

    logic          mul_start;
    logic          mul_clr;
    logic          mul_busy;
    logic          mul_done;
    logic [DW-1:0] mul_prod;

    // ---- stage p0: operand forwarding, ALU, hazard decision ----
    always_comb begin
        a_p0      = fwd_mux(bus.fwd_a_sel, bus.d1_in, bus.mem_fwd_data, bus.wb_fwd_data);
        bf_p0     = fwd_mux(bus.fwd_b_sel, bus.d2_in, bus.mem_fwd_data, bus.wb_fwd_data);
        b_p0      = bus.asrc_in ? bus.imm_in : bf_p0;
        alu_p0    = alu_fn(bus.aluop_in, bus.func_in, a_p0, b_p0);
        is_mul_p0 = (bus.aluop_in == ALUOP_RTYPE) && (bus.func_in == FUNC_MUL);
        ctl_p0    = '{rwrite: bus.rwrite_in, mreg: bus.mreg_in,
                      mread: bus.mread_in, mwrite: bus.mwrite_in};
        // DONE re-presents the held mul instruction, now with its product
        take_p0   = ((state == EX_IDLE) && !is_mul_p0) || (state == EX_DONE);
        res_p0    = (state == EX_DONE) ? mul_prod : alu_p0;
    end

    // reset and flush win over the stall so the front end is released immediately
    assign stall_p0  = !rst && !bus.flush_in &&
                       (((state == EX_IDLE) && is_mul_p0) || (state == EX_MUL));
    assign mul_start = stall_p0 && (state == EX_IDLE);
    assign mul_clr   = rst || bus.flush_in;

    mul16_iter #(
        .DW      (DW),
        .MUL_LEN (MUL_LEN)
    ) u_mul (
        .clk     (clk),
        .rst     (mul_clr),
        .start   (mul_start),
        .a       (a_p0),
        .b       (b_p0),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // ---- stage p1: EX/MEM register and multiply sequencer ----
    always_ff @(posedge clk) begin
        if (rst || bus.flush_in) begin
            state    <= EX_IDLE;
            alu_p1   <= '0;
            sdata_p1 <= '0;
            wreg_p1  <= '0;
            ctl_p1   <= '0;
        end else begin
            case (state)
                EX_IDLE: if (is_mul_p0) state <= EX_MUL;
                EX_MUL:  if (mul_done || !mul_busy) state <= EX_DONE;
                default: state <= EX_IDLE;
            endcase
            if (take_p0) begin
                alu_p1   <= res_p0;
                sdata_p1 <= bf_p0;
                wreg_p1  <= bus.wreg_in;
                ctl_p1   <= ctl_p0;
            end else begin
                alu_p1   <= '0;
                sdata_p1 <= '0;
                wreg_p1  <= '0;
                ctl_p1   <= '0;
            end
        end
    end

    assign bus.alu_out    = alu_p1;
    assign bus.sdata_out  = sdata_p1;
    assign bus.wreg_out   = wreg_p1;
    assign bus.rwrite_out = ctl_p1.rwrite;
    assign bus.mreg_out   = ctl_p1.mreg;
    assign bus.mread_out  = ctl_p1.mread;
    assign bus.mwrite_out = ctl_p1.mwrite;
    assign bus.stall_out  = stall_p0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the EX/MEM outputs and stall.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_stage_if #(.DW(16)) bus ();

    ex_mem_stage #(.DW(16), .MUL_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [2:0]  wreg;
        logic [3:0]  ctl;
        string       name;
    } out_exp_t;

    typedef struct {
        int    cyc;
        logic  stall;
        string name;
    } stall_exp_t;

    out_exp_t   out_q[$];
    stall_exp_t stall_q[$];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every expectation due at or before this cycle is popped and checked
    always @(negedge clk) begin
        stall_exp_t se;
        out_exp_t   oe;
        logic [3:0] act_ctl;
        while (stall_q.size() > 0 && stall_q[0].cyc <= cyc) begin
            se = stall_q.pop_front();
            n_tests++;
            if (se.cyc != cyc || bus.stall_out !== se.stall) begin
                n_fail++;
                $display("FAIL %s stall @cyc %0d (due %0d): got %b, want %b",
                         se.name, cyc, se.cyc, bus.stall_out, se.stall);
            end
        end
        while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
            oe = out_q.pop_front();
            n_tests++;
            act_ctl = {bus.rwrite_out, bus.mreg_out, bus.mread_out, bus.mwrite_out};
            if (oe.cyc != cyc || bus.alu_out !== oe.alu || bus.sdata_out !== oe.sdata ||
                bus.wreg_out !== oe.wreg || act_ctl !== oe.ctl) begin
                n_fail++;
                $display("FAIL %s out @cyc %0d (due %0d): got alu=%h sdata=%h wreg=%0d ctl=%b, want alu=%h sdata=%h wreg=%0d ctl=%b",
                         oe.name, cyc, oe.cyc, bus.alu_out, bus.sdata_out, bus.wreg_out,
                         act_ctl, oe.alu, oe.sdata, oe.wreg, oe.ctl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        bus.flush_in = 1'b0;     bus.d1_in = '0;        bus.d2_in = '0;
        bus.imm_in = '0;         bus.wreg_in = '0;      bus.func_in = '0;
        bus.aluop_in = '0;       bus.rwrite_in = 1'b0;  bus.mreg_in = 1'b0;
        bus.mread_in = 1'b0;     bus.mwrite_in = 1'b0;  bus.asrc_in = 1'b0;
        bus.fwd_a_sel = FWD_IDEX; bus.fwd_b_sel = FWD_IDEX;
        bus.mem_fwd_data = '0;   bus.wb_fwd_data = '0;
    endtask

    task automatic rand_in();
        bus.flush_in = 1'(($urandom));  bus.d1_in = 16'($urandom);
        bus.d2_in = 16'($urandom);      bus.imm_in = 16'($urandom);
        bus.wreg_in = 3'($urandom);     bus.func_in = 3'($urandom);
        bus.aluop_in = 2'($urandom);    bus.rwrite_in = 1'($urandom);
        bus.mreg_in = 1'($urandom);     bus.mread_in = 1'($urandom);
        bus.mwrite_in = 1'($urandom);   bus.asrc_in = 1'($urandom);
        bus.fwd_a_sel = 2'($urandom);   bus.fwd_b_sel = 2'($urandom);
        bus.mem_fwd_data = 16'($urandom); bus.wb_fwd_data = 16'($urandom);
    endtask

    task automatic set_op(input logic [1:0] aluop, input logic [2:0] func,
                          input logic [15:0] d1, input logic [15:0] d2,
                          input logic [15:0] imm, input logic asrc,
                          input logic [2:0] wreg, input logic [3:0] ctl);
        clear_in();
        bus.aluop_in = aluop; bus.func_in = func;
        bus.d1_in = d1; bus.d2_in = d2; bus.imm_in = imm; bus.asrc_in = asrc;
        bus.wreg_in = wreg;
        {bus.rwrite_in, bus.mreg_in, bus.mread_in, bus.mwrite_in} = ctl;
    endtask

    task automatic push_stall(input string n, input int c, input logic s);
        stall_exp_t e;
        e.cyc = c; e.stall = s; e.name = n;
        stall_q.push_back(e);
    endtask

    task automatic push_out(input string n, input int c, input logic [15:0] alu,
                            input logic [15:0] sdata, input logic [2:0] wreg,
                            input logic [3:0] ctl);
        out_exp_t e;
        e.cyc = c; e.alu = alu; e.sdata = sdata; e.wreg = wreg; e.ctl = ctl; e.name = n;
        out_q.push_back(e);
    endtask

    // single-cycle instruction: no stall now, registered result after the next edge
    task automatic issue(input string n, input logic [15:0] alu, input logic [15:0] sdata,
                         input logic [2:0] wreg, input logic [3:0] ctl);
        push_stall(n, cyc, 1'b0);
        push_out(n, cyc + 1, alu, sdata, wreg, ctl);
        tick();
    endtask

    // multiply held in EX; abort_kind 0 = flush, 1 = reset at stall cycle abort_at+1
    task automatic mul_seq(input string n, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] wreg, input logic [15:0] prod,
                           input int abort_at, input int abort_kind);
        int c;
        c = cyc;
        set_op(ALUOP_RTYPE, FUNC_MUL, a, b, 16'h0, 1'b0, wreg, 4'b1000);
        for (int k = 0; k < 18; k++) begin
            if (k >= 1) push_out({n, "_bubble"}, c + k, 16'h0, 16'h0, 3'd0, 4'b0000);
            if (abort_at >= 0 && k == abort_at) begin
                if (abort_kind == 0) bus.flush_in = 1'b1;
                else rst = 1'b1;
                push_stall({n, "_abort"}, c + k, 1'b0);
                push_out({n, "_abort"}, c + k + 1, 16'h0, 16'h0, 3'd0, 4'b0000);
                tick();
                rst = 1'b0;
                clear_in();
                return;
            end
            if (k == 3) bus.fwd_a_sel = FWD_MEM;
            if (k >= 3 && k <= 10) bus.mem_fwd_data = 16'($urandom);
            if (k == 11) bus.fwd_a_sel = FWD_IDEX;
            push_stall(n, c + k, (k < 17));
            if (k == 17) push_out({n, "_result"}, c + 18, prod, b, wreg, 4'b1000);
            tick();
        end
    endtask

    initial begin
        // 1. reset with random inputs, then an immediate add
        rst = 1'b1;
        rand_in();
        tick();
        push_out("rst", 1, 16'h0, 16'h0, 3'd0, 4'b0000);
        rand_in();
        push_stall("rst", 1, 1'b0);
        push_out("rst", 2, 16'h0, 16'h0, 3'd0, 4'b0000);
        tick();
        rst = 1'b0;
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0005, 16'h0000, 16'h0003, 1'b1, 3'd3, 4'b1000);
        issue("add_imm", 16'h0008, 16'h0000, 3'd3, 4'b1000);

        // 2. wrap, signed compare, shift amount modulo 16, logic ops, pass, load/store
        set_op(ALUOP_RTYPE, FUNC_SUB, 16'h0000, 16'h0001, 16'h0, 1'b0, 3'd1, 4'b1000);
        issue("sub_wrap", 16'hFFFF, 16'h0001, 3'd1, 4'b1000);
        set_op(ALUOP_RTYPE, FUNC_SLT, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 3'd1, 4'b1000);
        issue("slt_neg", 16'h0001, 16'h0001, 3'd1, 4'b1000);
        set_op(ALUOP_RTYPE, FUNC_SLT, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 3'd1, 4'b1000);
        issue("slt_pos", 16'h0000, 16'hFFFF, 3'd1, 4'b1000);
        set_op(ALUOP_RTYPE, FUNC_SHL, 16'h0001, 16'h0013, 16'h0, 1'b0, 3'd2, 4'b1000);
        issue("shl_mod16", 16'h0008, 16'h0013, 3'd2, 4'b1000);
        set_op(ALUOP_RTYPE, FUNC_AND, 16'hF0F0, 16'hFF00, 16'h0, 1'b0, 3'd3, 4'b1000);
        issue("and", 16'hF000, 16'hFF00, 3'd3, 4'b1000);
        set_op(ALUOP_RTYPE, FUNC_OR, 16'hF0F0, 16'hFF00, 16'h0, 1'b0, 3'd3, 4'b1000);
        issue("or", 16'hFFF0, 16'hFF00, 3'd3, 4'b1000);
        set_op(ALUOP_RTYPE, FUNC_XOR, 16'hF0F0, 16'hFF00, 16'h0, 1'b0, 3'd3, 4'b1000);
        issue("xor", 16'h0FF0, 16'hFF00, 3'd3, 4'b1000);
        set_op(ALUOP_SUB, FUNC_ADD, 16'h0010, 16'h0020, 16'h0, 1'b0, 3'd4, 4'b1000);
        issue("aluop_sub", 16'hFFF0, 16'h0020, 3'd4, 4'b1000);
        set_op(ALUOP_PASS, FUNC_ADD, 16'h1111, 16'h2222, 16'hBEEF, 1'b1, 3'd4, 4'b1000);
        issue("pass_imm", 16'hBEEF, 16'h2222, 3'd4, 4'b1000);
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0100, 16'h0055, 16'h0004, 1'b1, 3'd7, 4'b1110);
        issue("load", 16'h0104, 16'h0055, 3'd7, 4'b1110);

        // 3. forwarding
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0000, 16'h0001, 16'h0, 1'b0, 3'd2, 4'b1000);
        bus.fwd_a_sel = FWD_MEM; bus.mem_fwd_data = 16'h1234;
        issue("fwd_a_mem", 16'h1235, 16'h0001, 3'd2, 4'b1000);
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0000, 16'h0001, 16'h0, 1'b0, 3'd0, 4'b0001);
        bus.fwd_a_sel = FWD_MEM; bus.mem_fwd_data = 16'h1234;
        bus.fwd_b_sel = FWD_WB;  bus.wb_fwd_data = 16'h00FF;
        issue("fwd_b_wb", 16'h1333, 16'h00FF, 3'd0, 4'b0001);
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0007, 16'h0002, 16'h0, 1'b0, 3'd1, 4'b1000);
        bus.fwd_a_sel = 2'b11; bus.fwd_b_sel = 2'b11;
        bus.mem_fwd_data = 16'hAAAA; bus.wb_fwd_data = 16'h5555;
        issue("fwd_sel11", 16'h0009, 16'h0002, 3'd1, 4'b1000);
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0000, 16'h0000, 16'h0010, 1'b1, 3'd0, 4'b0001);
        bus.fwd_b_sel = FWD_WB; bus.wb_fwd_data = 16'h0077;
        issue("store_fwd", 16'h0010, 16'h0077, 3'd0, 4'b0001);

        // 4. multiply, then back-to-back
        mul_seq("mul_12x34", 16'h0012, 16'h0034, 3'd5, 16'h03A8, -1, 0);
        mul_seq("mul_ffxff", 16'hFFFF, 16'hFFFF, 3'd6, 16'h0001, -1, 0);
        clear_in();
        issue("after_mul", 16'h0000, 16'h0000, 3'd0, 4'b0000);

        // 5. flush on stall cycle 5, reset on stall cycle 9
        mul_seq("mul_flush", 16'h0021, 16'h0003, 3'd1, 16'h0063, 4, 0);
        set_op(ALUOP_MEM, FUNC_ADD, 16'h0002, 16'h0003, 16'h0, 1'b0, 3'd2, 4'b1000);
        issue("add_after_flush", 16'h0005, 16'h0003, 3'd2, 4'b1000);
        for (int i = 0; i < 18; i++) begin
            clear_in();
            issue("flush_quiet", 16'h0000, 16'h0000, 3'd0, 4'b0000);
        end
        mul_seq("mul_rst", 16'h0003, 16'h0005, 3'd3, 16'h000F, 8, 1);
        for (int i = 0; i < 20; i++) begin
            clear_in();
            issue("rst_no_product", 16'h0000, 16'h0000, 3'd0, 4'b0000);
        end

        tick();
        tick();
        @(negedge clk);
        #1;
        n_tests++;
        if (out_q.size() != 0 || stall_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0",
                     out_q.size(), stall_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
